// File: rtl/player_ctrl_pkg.sv
// Shared types and constants for the player horizontal-move controller.
package player_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STUN   = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } dir_t;

  localparam int EDGE_TOP    = 3;
  localparam int EDGE_RIGHT  = 2;
  localparam int EDGE_BOTTOM = 1;
  localparam int EDGE_LEFT   = 0;

endpackage

// File: rtl/player_dir_arbiter.sv
// Resolves held keys, frame-sampled previous keys, last direction and edge
// hits into the direction to issue this frame.
module player_dir_arbiter
  import player_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       start_of_frame,
  input  logic       key_left,
  input  logic       key_right,
  input  dir_t       last_dir,
  input  logic [3:0] edge_latch,
  output dir_t       dir
);

  logic prev_left_reg;
  logic prev_right_reg;
  logic new_left;
  logic new_right;
  dir_t req_dir;
  logic unused_edges;

  // Key history only advances per frame, so sub-frame taps never look "new".
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prev_left_reg  <= 1'b0;
      prev_right_reg <= 1'b0;
    end else if (start_of_frame) begin
      prev_left_reg  <= key_left;
      prev_right_reg <= key_right;
    end
  end

  assign new_left     = key_left & ~prev_left_reg;
  assign new_right    = key_right & ~prev_right_reg;
  assign unused_edges = ^{edge_latch[EDGE_TOP], edge_latch[EDGE_BOTTOM]};

  always_comb begin
    req_dir = NONE;
    if (key_left && !key_right) begin
      req_dir = LEFT;
    end else if (key_right && !key_left) begin
      req_dir = RIGHT;
    end else if (key_left && key_right) begin
      if (new_left)       req_dir = LEFT;
      else if (new_right) req_dir = RIGHT;
      else                req_dir = last_dir;
    end

    dir = req_dir;
    if (req_dir == LEFT && edge_latch[EDGE_LEFT])   dir = NONE;
    if (req_dir == RIGHT && edge_latch[EDGE_RIGHT]) dir = NONE;
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Frame-rate FSM driving the player mover: active-low move commands, ramped
// X speed, collision stun lockout and edge blocking.
module player_move_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int MIN_SPEED   = 10,
  parameter int MAX_SPEED   = 64,
  parameter int ACCEL       = 4,
  parameter int STUN_FRAMES = 15,
  parameter int SPEED_W     = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               gameEnable,
  input  logic               keyLeft,
  input  logic               keyRight,
  input  logic               collision,
  input  logic [3:0]         HitEdgeCode,
  output logic               moveLeftN,
  output logic               moveRightN,
  output logic [SPEED_W-1:0] xSpeed,
  output logic               stunActive,
  output logic [1:0]         ctrlState
);

  localparam logic [SPEED_W-1:0] MIN_V       = SPEED_W'(MIN_SPEED);
  localparam logic [SPEED_W-1:0] MAX_V       = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W:0]   MAX_W       = (SPEED_W+1)'(MAX_SPEED);
  localparam logic [SPEED_W:0]   ACCEL_W     = (SPEED_W+1)'(ACCEL);
  localparam logic [7:0]         STUN_RELOAD = 8'(STUN_FRAMES - 1);

  ctrl_state_t        state_reg, state_next;
  dir_t               last_dir_reg, last_dir_next;
  dir_t               arb_dir;
  logic [7:0]         cnt_reg, cnt_next;
  logic               left_n_reg, left_n_next;
  logic               right_n_reg, right_n_next;
  logic [SPEED_W-1:0] speed_reg, speed_next;
  logic               col_latch_reg;
  logic [3:0]         edge_latch_reg;
  logic [SPEED_W:0]   speed_sum;
  logic [SPEED_W-1:0] speed_sat;
  logic               do_move;

  // Events landing on the consuming cycle seed the next frame's latch.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      col_latch_reg  <= 1'b0;
      edge_latch_reg <= 4'd0;
    end else if (startOfFrame) begin
      col_latch_reg  <= collision;
      edge_latch_reg <= HitEdgeCode;
    end else begin
      col_latch_reg  <= col_latch_reg | collision;
      edge_latch_reg <= edge_latch_reg | HitEdgeCode;
    end
  end

  player_dir_arbiter u_arb (
    .clk            (clk),
    .resetN         (resetN),
    .start_of_frame (startOfFrame),
    .key_left       (keyLeft),
    .key_right      (keyRight),
    .last_dir       (last_dir_reg),
    .edge_latch     (edge_latch_reg),
    .dir            (arb_dir)
  );

  assign speed_sum = {1'b0, speed_reg} + ACCEL_W;
  assign speed_sat = (speed_sum > MAX_W) ? MAX_V : speed_sum[SPEED_W-1:0];

  always_comb begin
    state_next    = state_reg;
    last_dir_next = last_dir_reg;
    cnt_next      = cnt_reg;
    left_n_next   = left_n_reg;
    right_n_next  = right_n_reg;
    speed_next    = speed_reg;
    do_move       = 1'b0;

    if (startOfFrame) begin
      left_n_next  = 1'b1;
      right_n_next = 1'b1;
      speed_next   = MIN_V;
      case (state_reg)
        IDLE: begin
          last_dir_next = NONE;
          if (gameEnable) state_next = ACTIVE;
        end
        ACTIVE: begin
          if (!gameEnable) begin
            state_next    = IDLE;
            last_dir_next = NONE;
          end else if (col_latch_reg) begin
            state_next    = STUN;
            cnt_next      = STUN_RELOAD;
            last_dir_next = NONE;
          end else begin
            do_move = 1'b1;
          end
        end
        STUN: begin
          if (!gameEnable) begin
            state_next = IDLE;
            cnt_next   = 8'd0;
          end else if (col_latch_reg) begin
            cnt_next = STUN_RELOAD;
          end else if (cnt_reg == 8'd0) begin
            state_next = ACTIVE;
            do_move    = 1'b1;
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
        default: state_next = IDLE;
      endcase

      // lastDir is NONE on stun exit, so the ramp restarts from MIN there.
      if (do_move) begin
        left_n_next   = (arb_dir != LEFT);
        right_n_next  = (arb_dir != RIGHT);
        speed_next    = (arb_dir == last_dir_reg && arb_dir != NONE) ? speed_sat : MIN_V;
        last_dir_next = arb_dir;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg    <= IDLE;
      last_dir_reg <= NONE;
      cnt_reg      <= 8'd0;
      left_n_reg   <= 1'b1;
      right_n_reg  <= 1'b1;
      speed_reg    <= MIN_V;
    end else begin
      state_reg    <= state_next;
      last_dir_reg <= last_dir_next;
      cnt_reg      <= cnt_next;
      left_n_reg   <= left_n_next;
      right_n_reg  <= right_n_next;
      speed_reg    <= speed_next;
    end
  end

  assign moveLeftN  = left_n_reg;
  assign moveRightN = right_n_reg;
  assign xSpeed     = speed_reg;
  assign stunActive = (state_reg == STUN);
  assign ctrlState  = state_reg;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: ramp, saturation, arbitration,
// stun timing, edge blocking and asynchronous reset.
module tb_player_move_ctrl;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       gameEnable;
  logic       keyLeft;
  logic       keyRight;
  logic       collision;
  logic [3:0] HitEdgeCode;
  logic       moveLeftN;
  logic       moveRightN;
  logic [7:0] xSpeed;
  logic       stunActive;
  logic [1:0] ctrlState;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  player_move_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .gameEnable   (gameEnable),
    .keyLeft      (keyLeft),
    .keyRight     (keyRight),
    .collision    (collision),
    .HitEdgeCode  (HitEdgeCode),
    .moveLeftN    (moveLeftN),
    .moveRightN   (moveRightN),
    .xSpeed       (xSpeed),
    .stunActive   (stunActive),
    .ctrlState    (ctrlState)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One line per frame checked: left_n, right_n, speed, stun, state.
  task automatic chk_frame(input string tag, input logic l, input logic r,
                           input int spd, input logic st, input int state);
    chk({tag, ".moveLeftN"}, {31'd0, moveLeftN}, {31'd0, l});
    chk({tag, ".moveRightN"}, {31'd0, moveRightN}, {31'd0, r});
    chk({tag, ".xSpeed"}, {24'd0, xSpeed}, spd);
    chk({tag, ".stunActive"}, {31'd0, stunActive}, {31'd0, st});
    chk({tag, ".ctrlState"}, {30'd0, ctrlState}, state);
    $display("%s: L=%0b R=%0b spd=%0d stun=%0b st=%0d", tag, moveLeftN, moveRightN,
             xSpeed, stunActive, ctrlState);
  endtask

  // Frame = one startOfFrame cycle plus three quiet cycles; ends on a negedge.
  task automatic do_frame();
    @(negedge clk) startOfFrame = 1'b1;
    @(negedge clk) startOfFrame = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_col();
    collision = 1'b1;
    @(negedge clk) collision = 1'b0;
  endtask

  task automatic pulse_edge(input logic [3:0] code);
    HitEdgeCode = code;
    @(negedge clk) HitEdgeCode = 4'd0;
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; gameEnable = 1'b0;
    keyLeft = 1'b0; keyRight = 1'b0; collision = 1'b0; HitEdgeCode = 4'd0;
    repeat (3) @(negedge clk);
    chk_frame("reset", 1, 1, 10, 0, 0);
    resetN = 1'b1;

    // Right held from reset: first frame only enters ACTIVE.
    gameEnable = 1'b1; keyRight = 1'b1;
    do_frame();
    chk_frame("right_f1", 1, 1, 10, 0, 1);
    for (int i = 0; i < 10; i++) begin
      do_frame();
      chk_frame($sformatf("right_f%0d", i + 2), 1, 0, 10 + 4 * i, 0, 1);
    end

    // Left 20 frames: ramp then saturate at 64.
    keyRight = 1'b0; keyLeft = 1'b1;
    for (int i = 0; i < 20; i++) begin
      do_frame();
      chk_frame($sformatf("left_f%0d", i + 1), 0, 1, (10 + 4 * i > 64) ? 64 : 10 + 4 * i, 0, 1);
    end
    keyLeft = 1'b0; keyRight = 1'b1;
    do_frame();
    chk_frame("switch_right", 1, 0, 10, 0, 1);

    // Hold left, press right on frame 5.
    keyRight = 1'b0; keyLeft = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_frame();
      chk_frame($sformatf("hold_left_f%0d", i + 1), 0, 1, 10 + 4 * i, 0, 1);
    end
    keyRight = 1'b1;
    do_frame();
    chk_frame("new_right_wins", 1, 0, 10, 0, 1);
    do_frame();
    chk_frame("both_keep_last", 1, 0, 14, 0, 1);
    keyRight = 1'b0;
    do_frame();
    chk_frame("left_resumes", 0, 1, 10, 0, 1);

    // Both pressed together from nothing: left wins.
    keyLeft = 1'b0;
    do_frame();
    chk_frame("no_keys", 1, 1, 10, 0, 1);
    keyLeft = 1'b1; keyRight = 1'b1;
    do_frame();
    chk_frame("both_new_left", 0, 1, 10, 0, 1);
    do_frame();
    chk_frame("both_held_left", 0, 1, 14, 0, 1);

    // Collision in frame N: 15 stun frames then right at 10.
    keyLeft = 1'b0;
    do_frame();
    chk_frame("stun_N", 1, 0, 10, 0, 1);
    pulse_col();
    for (int i = 1; i <= 15; i++) begin
      do_frame();
      chk_frame($sformatf("stun_N+%0d", i), 1, 1, 10, 1, 2);
    end
    do_frame();
    chk_frame("stun_exit", 1, 0, 10, 0, 1);
    do_frame();
    chk_frame("stun_exit_ramp", 1, 0, 14, 0, 1);

    // Second collision in frame M+5 stretches the stun through M+20.
    pulse_col();
    for (int i = 1; i <= 20; i++) begin
      do_frame();
      chk_frame($sformatf("ext_M+%0d", i), 1, 1, 10, 1, 2);
      if (i == 5) pulse_col();
    end
    do_frame();
    chk_frame("ext_exit", 1, 0, 10, 0, 1);

    // Left-edge hit blocks one frame; top-edge hit is ignored.
    keyRight = 1'b0; keyLeft = 1'b1;
    do_frame();
    chk_frame("edge_pre1", 0, 1, 10, 0, 1);
    do_frame();
    chk_frame("edge_pre2", 0, 1, 14, 0, 1);
    pulse_edge(4'b0001);
    do_frame();
    chk_frame("edge_block", 1, 1, 10, 0, 1);
    do_frame();
    chk_frame("edge_resume", 0, 1, 10, 0, 1);
    pulse_edge(4'b1000);
    do_frame();
    chk_frame("edge_top_ignored", 0, 1, 14, 0, 1);

    // Collision on the startOfFrame cycle itself is deferred one frame.
    @(negedge clk) begin startOfFrame = 1'b1; collision = 1'b1; end
    @(negedge clk) begin startOfFrame = 1'b0; collision = 1'b0; end
    repeat (3) @(negedge clk);
    chk_frame("sof_col_frame", 0, 1, 18, 0, 1);
    do_frame();
    chk_frame("sof_col_stun", 1, 1, 10, 1, 2);

    // Asynchronous reset mid-stun, away from any clock edge.
    #2 resetN = 1'b0;
    #1 chk_frame("async_reset", 1, 1, 10, 0, 0);
    @(negedge clk) resetN = 1'b1;

    // gameEnable drop in ACTIVE returns to IDLE.
    do_frame();
    chk_frame("ge_enter", 1, 1, 10, 0, 1);
    do_frame();
    chk_frame("ge_move", 0, 1, 10, 0, 1);
    gameEnable = 1'b0;
    do_frame();
    chk_frame("ge_off_idle", 1, 1, 10, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Frame-rate controller that sequences the player horizontal-move datapath.
- Converts raw keyboard levels into active-low per-frame move commands and a ramped X speed (1/64-pixel fixed point) for the player mover.
- Applies a collision stun lockout and edge blocking.
- Sits between the keyboard decoder / collision logic and the player mover; all decisions are taken on startOfFrame (30 Hz).

Parameters:
- MIN_SPEED, 10, X speed after reset, release or direction change (1/64 px per frame).
- MAX_SPEED, 64, speed saturation value.
- ACCEL, 4, speed increment per frame of sustained same-direction movement.
- STUN_FRAMES, 15, number of frames with movement suppressed after a collision (range 1..255).
- SPEED_W, 8, width of xSpeed.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- gameEnable  in  1  level; 0 freezes the player.
- keyLeft  in  1  level, active-high, left key held.
- keyRight  in  1  level, active-high, right key held.
- collision  in  1  pixel-time pulse(s), player hit an object.
- HitEdgeCode  in  4  pixel-time edge flags: bit3 top, bit2 right, bit1 bottom, bit0 left.
- moveLeftN  out  1  active-low move-left command to mover.
- moveRightN  out  1  active-low move-right command to mover.
- xSpeed  out  SPEED_W  speed magnitude to mover.
- stunActive  out  1  high while in STUN.
- ctrlState  out  2  encoded FSM state, for debug/HUD.

Behaviour:
- Reset values (asynchronous, resetN=0, any state): moveLeftN=1, moveRightN=1, xSpeed=MIN_SPEED, stunActive=0, ctrlState=IDLE, stun counter=0, lastDir=NONE, all latches cleared.
- Frame latches (every cycle):
  - colLatch |= collision.
  - edgeLatch |= HitEdgeCode.
  - On a startOfFrame cycle both latches are consumed and cleared.
  - A collision or edge event arriving in that same cycle is kept for the next frame, not lost.
- Update timing: all outputs change only on the clock edge where startOfFrame=1. The mover consumes them at the following startOfFrame, giving one frame of latency.
- FSM states: IDLE=0, ACTIVE=1, STUN=2.
- IDLE:
  - Outputs idle: both N outputs 1, xSpeed=MIN_SPEED.
  - At startOfFrame with gameEnable=1, go to ACTIVE. No move is issued on that frame.
- ACTIVE, at each startOfFrame, first matching rule wins:
  - gameEnable=0: go to IDLE, outputs idle.
  - colLatch=1: go to STUN, load counter=STUN_FRAMES-1, outputs idle, xSpeed=MIN_SPEED, lastDir=NONE.
  - Otherwise compute the requested direction:
    - Only keyLeft held: LEFT.
    - Only keyRight held: RIGHT.
    - Both held: the key newly pressed this frame wins. If both are new, LEFT wins. If neither is new, lastDir is kept.
    - Neither held: NONE.
  - Edge blocking: LEFT with edgeLatch[0]=1 becomes NONE; RIGHT with edgeLatch[2]=1 becomes NONE. Bits 3 and 1 are ignored.
  - Outputs: LEFT gives moveLeftN=0, moveRightN=1. RIGHT gives the mirror. NONE gives both 1. Never both 0.
  - Speed:
    - Direction equals lastDir and is not NONE: xSpeed = min(xSpeed+ACCEL, MAX_SPEED). Compute in SPEED_W+1 bits, no wrap.
    - Otherwise: xSpeed=MIN_SPEED.
    - lastDir is updated to the direction issued.
- STUN, at each startOfFrame:
  - gameEnable=0: go to IDLE.
  - Else colLatch=1: reload counter=STUN_FRAMES-1 (stun is extended).
  - Else counter==0: go to ACTIVE and evaluate keys with the ACTIVE rules in that same cycle. Speed restarts at MIN_SPEED.
  - Else: decrement the counter, outputs idle.
  - Result: exactly STUN_FRAMES idle frames when there is no further collision.
- stunActive=1 iff state==STUN (registered with the state).
- Key-edge detection: previous key levels are sampled only at startOfFrame. A press shorter than one frame is ignored.

Decomposition:
- Package player_ctrl_pkg:
  - enum ctrl_state_t {IDLE, ACTIVE, STUN} (2 bits).
  - enum dir_t {NONE, LEFT, RIGHT}.
  - Edge bit index constants EDGE_TOP=3, EDGE_RIGHT=2, EDGE_BOTTOM=1, EDGE_LEFT=0.
- One natural sub-module: player_dir_arbiter. It is combinational plus the previous-key registers. It maps keys, previous keys, lastDir and edgeLatch to dir_t.
- The FSM, stun counter, speed ramp and latches stay in player_move_ctrl.

Test Plan:
- Reset then gameEnable=1, keyRight held 10 frames: frame 1 idle; frames 2..11 moveRightN=0, moveLeftN=1, xSpeed=10,14,18,...,46.
- keyLeft held 20 frames: xSpeed ramps 10→...→62→64 and stays 64 (saturation). Switch to keyRight: the next frame gives xSpeed=10, moveRightN=0.
- Hold keyLeft, press keyRight on frame 5: right wins from frame 5 with xSpeed=10. Release right: left resumes with xSpeed=10. Both pressed in the same frame from none: left.
- collision pulse mid-frame N, keyRight held: frames N+1..N+15 both N outputs 1, stunActive=1. Frame N+16 moveRightN=0, xSpeed=10. A second pulse in frame N+5 extends the stun to end at N+20.
- keyLeft held with HitEdgeCode[0] pulse in frame N: frame N+1 both outputs 1 and xSpeed=10; frame N+2 moves left again. A bit3 pulse has no effect.
- resetN low mid-STUN: outputs immediately return to reset values (asynchronous). gameEnable=0 in ACTIVE: next frame IDLE, both outputs 1.
